// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : HH:MM:SS down-counter with load/start/pause/clear strobes,
//            1 Hz tick enable and registered expiry indication.
// Revision : 1.0 - initial release
// ============================================================================

module countdown_timer #(
    parameter int MAX_HOURS = 23,
    parameter int SEC_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_h,
    input  logic [7:0] load_m,
    input  logic [7:0] load_s,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [7:0] c_MAX_HOURS = 8'(MAX_HOURS);
    localparam logic [7:0] c_SEC_LIMIT = 8'(SEC_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_hours;
    logic [7:0] r_minutes;
    logic [7:0] r_seconds;
    logic       r_running;
    logic       r_expired;
    logic       r_done;

    logic [7:0] w_hours_nxt;
    logic [7:0] w_minutes_nxt;
    logic [7:0] w_seconds_nxt;
    logic       w_done_nxt;

    logic [7:0] w_sat_h;
    logic [7:0] w_sat_m;
    logic [7:0] w_sat_s;

    logic [7:0] w_dec_h;
    logic [7:0] w_dec_m;
    logic [7:0] w_dec_s;
    logic       w_dec_zero;
    logic       w_cur_zero;

    // Preset saturation keeps every digit inside its legal range.
    always_comb begin
        w_sat_h = (load_h > c_MAX_HOURS) ? c_MAX_HOURS : load_h;
        w_sat_m = (load_m > c_SEC_LIMIT) ? c_SEC_LIMIT : load_m;
        w_sat_s = (load_s > c_SEC_LIMIT) ? c_SEC_LIMIT : load_s;
    end

    // Borrow chain: seconds borrow from minutes, minutes from hours.
    always_comb begin
        w_dec_h = r_hours;
        w_dec_m = r_minutes;
        w_dec_s = r_seconds;
        if (r_seconds != 8'd0) begin
            w_dec_s = r_seconds - 8'd1;
        end else if (r_minutes != 8'd0) begin
            w_dec_s = c_SEC_LIMIT;
            w_dec_m = r_minutes - 8'd1;
        end else if (r_hours != 8'd0) begin
            w_dec_s = c_SEC_LIMIT;
            w_dec_m = c_SEC_LIMIT;
            w_dec_h = r_hours - 8'd1;
        end
    end

    assign w_cur_zero = (r_hours == 8'd0) && (r_minutes == 8'd0) && (r_seconds == 8'd0);
    assign w_dec_zero = (w_dec_h == 8'd0) && (w_dec_m == 8'd0) && (w_dec_s == 8'd0);

    // Commands resolved by priority; a command not legal in the current
    // state is treated as absent so lower-priority inputs still apply.
    always_comb begin
        w_state_nxt   = r_state;
        w_hours_nxt   = r_hours;
        w_minutes_nxt = r_minutes;
        w_seconds_nxt = r_seconds;
        w_done_nxt    = 1'b0;

        if (clear) begin
            w_state_nxt   = ST_IDLE;
            w_hours_nxt   = 8'd0;
            w_minutes_nxt = 8'd0;
            w_seconds_nxt = 8'd0;
        end else if (load && (r_state != ST_RUN)) begin
            w_state_nxt   = ST_IDLE;
            w_hours_nxt   = w_sat_h;
            w_minutes_nxt = w_sat_m;
            w_seconds_nxt = w_sat_s;
        end else if (pause && (r_state == ST_RUN)) begin
            w_state_nxt = ST_PAUSED;
        end else if (start && ((r_state == ST_IDLE) || (r_state == ST_PAUSED)) && !w_cur_zero) begin
            w_state_nxt = ST_RUN;
        end else if (tick && (r_state == ST_RUN) && !w_cur_zero) begin
            w_hours_nxt   = w_dec_h;
            w_minutes_nxt = w_dec_m;
            w_seconds_nxt = w_dec_s;
            if (w_dec_zero) begin
                w_state_nxt = ST_EXPIRED;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_hours   <= 8'd0;
            r_minutes <= 8'd0;
            r_seconds <= 8'd0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hours   <= w_hours_nxt;
            r_minutes <= w_minutes_nxt;
            r_seconds <= w_seconds_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_expired <= (w_state_nxt == ST_EXPIRED);
            r_done    <= w_done_nxt;
        end
    end

    assign hours   = r_hours;
    assign minutes = r_minutes;
    assign seconds = r_seconds;
    assign running = r_running;
    assign expired = r_expired;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Purpose  : Scoreboard bench for countdown_timer; reference model tracks the
//            remaining time as a single seconds total.
// Revision : 1.0 - initial release
// ============================================================================

module tb_countdown_timer;

    localparam int MAX_H = 23;
    localparam int LIM   = 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] load_h = 8'd0, load_m = 8'd0, load_s = 8'd0;
    logic [7:0] hours, minutes, seconds;
    logic       running, expired, done;

    countdown_timer #(.MAX_HOURS(MAX_H), .SEC_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .start(start), .pause(pause), .clear(clear),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .running(running), .expired(expired), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] h, m, s;
        logic       run, exp, dn;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   t_rem = 0;
    int   mode  = M_IDLE;

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared after the edge.
    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb hours",   int'(hours),   int'(e.h));
            chk("sb minutes", int'(minutes), int'(e.m));
            chk("sb seconds", int'(seconds), int'(e.s));
            chk("sb running", int'(running), int'(e.run));
            chk("sb expired", int'(expired), int'(e.exp));
            chk("sb done",    int'(done),    int'(e.dn));
        end
    end

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Apply inputs for the next edge and push the model's view of the result.
    task automatic drive(bit ld, bit st, bit pa, bit cl, bit tk, int lh, int lm, int ls);
        exp_t e;
        bit   dn = 1'b0;
        load = ld; start = st; pause = pa; clear = cl; tick = tk;
        load_h = 8'(lh); load_m = 8'(lm); load_s = 8'(ls);
        if (cl) begin
            t_rem = 0; mode = M_IDLE;
        end else if (ld && mode != M_RUN) begin
            t_rem = min_i(lh, MAX_H) * 3600 + min_i(lm, LIM) * 60 + min_i(ls, LIM);
            mode  = M_IDLE;
        end else if (pa && mode == M_RUN) begin
            mode = M_PAUSED;
        end else if (st && (mode == M_IDLE || mode == M_PAUSED) && t_rem != 0) begin
            mode = M_RUN;
        end else if (tk && mode == M_RUN) begin
            t_rem = t_rem - 1;
            if (t_rem == 0) begin
                mode = M_EXP; dn = 1'b1;
            end
        end
        e.h   = 8'(t_rem / 3600);
        e.m   = 8'((t_rem % 3600) / 60);
        e.s   = 8'(t_rem % 60);
        e.run = (mode == M_RUN);
        e.exp = (mode == M_EXP);
        e.dn  = dn;
        sb.push_back(e);
    endtask

    task automatic step(bit ld, bit st, bit pa, bit cl, bit tk,
                        int lh = 0, int lm = 0, int ls = 0);
        @(negedge clk);
        #1;
        drive(ld, st, pa, cl, tk, lh, lm, ls);
    endtask

    // Direct check against constants after the previous step has settled.
    task automatic check_now(string n, int h, int m, int s, bit run, bit ex, bit dn);
        @(negedge clk);
        #2;
        chk({n, " hours"},   int'(hours),   h);
        chk({n, " minutes"}, int'(minutes), m);
        chk({n, " seconds"}, int'(seconds), s);
        chk({n, " running"}, int'(running), int'(run));
        chk({n, " expired"}, int'(expired), int'(ex));
        chk({n, " done"},    int'(done),    int'(dn));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #7;
        chk("reset hours",   int'(hours),   0);
        chk("reset running", int'(running), 0);
        chk("reset expired", int'(expired), 0);
        chk("reset done",    int'(done),    0);
        @(negedge clk); #1 rst_n = 1'b1;

        // Borrow from minutes
        step(1, 0, 0, 0, 0, 0, 1, 5);
        step(0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 1);
        check_now("t1a", 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        check_now("t1b", 0, 0, 59, 1, 0, 0);

        // Borrow from hours
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check_now("t2", 0, 59, 59, 1, 0, 0);

        // Expiry, done pulse, ignored commands afterwards
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 2);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_now("t3 enter", 0, 0, 0, 0, 1, 1);
        check_now("t3 after", 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        check_now("t3 hold", 0, 0, 0, 0, 1, 0);

        // Saturating load, start ignored at zero
        step(1, 0, 0, 0, 0, 99, 75, 80);
        check_now("t4 sat", 23, 59, 59, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        check_now("t4 zero start", 0, 0, 0, 0, 0, 0);

        // Pause with tick, start with tick, load during run
        step(1, 0, 0, 0, 0, 0, 0, 10);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        check_now("t5 pause", 0, 0, 9, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check_now("t5 resume", 0, 0, 8, 1, 0, 0);
        step(1, 0, 0, 0, 1, 5, 5, 5);
        check_now("t5 run load", 0, 0, 7, 1, 0, 0);

        // Asynchronous reset mid-countdown
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 10, 35);
        step(0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 1);
        check_now("t6 pre", 0, 10, 30, 1, 0, 0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async hours",   int'(hours),   0);
        chk("async minutes", int'(minutes), 0);
        chk("async seconds", int'(seconds), 0);
        chk("async running", int'(running), 0);
        t_rem = 0; mode = M_IDLE;
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) step(0, 0, 0, 0, 1);
        check_now("t6 post", 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 2, 3);
        check_now("t6 clr+load", 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        check_now("t6 idle", 0, 0, 0, 0, 0, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit ld, st, pa, cl, tk;
            int lh, lm, ls;
            ld = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 63) == 0);
            tk = ($urandom_range(0, 1) == 0);
            lh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 1));
            lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 2));
            ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 6));
            step(ld, st, pa, cl, tk, lh, lm, ls);
        end
        step(0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting HH:MM:SS timer; the borrow-chain counterpart to the up-counting clock counters (seconds/minutes/hours with carry).
- Loaded with a preset, decrements once per 1 Hz tick enable, raises an expiry indication at 00:00:00.
- Sits beside the clock datapath, shares its tick strobe, and drives the same 8-bit binary display digits.

Parameters:
- MAX_HOURS, 23, largest loadable hour value; larger load_h saturates to this.
- SEC_LIMIT, 59, wrap value for seconds and minutes on borrow.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle 1 Hz strobe; a decrement is allowed only on cycles where tick=1.
- load  input  1  one-cycle strobe; captures load_h/load_m/load_s.
- load_h  input  8  preset hours.
- load_m  input  8  preset minutes.
- load_s  input  8  preset seconds.
- start  input  1  one-cycle strobe; begin/resume countdown.
- pause  input  1  one-cycle strobe; freeze countdown.
- clear  input  1  one-cycle strobe; abort, zero all digits, go IDLE.
- hours  output  8  current hours.
- minutes  output  8  current minutes.
- seconds  output  8  current seconds.
- running  output  1  high in RUN state.
- expired  output  1  level, high in EXPIRED state.
- done  output  1  one-cycle pulse on the cycle entering EXPIRED.

Behaviour:
- Reset (rst_n=0, async): state IDLE; hours/minutes/seconds=0; running=0; expired=0; done=0.
- States:
  - IDLE: no decrement.
  - RUN: decrement on tick.
  - PAUSED: hold value.
  - EXPIRED: hold 00:00:00, expired=1.
- Command priority, same cycle: clear > load > pause > start > tick.
- clear (any state): digits=0, next state IDLE, done=0.
- load: accepted in IDLE, PAUSED and EXPIRED; ignored in RUN.
  - Captures saturated values: load_s>SEC_LIMIT gives SEC_LIMIT; same rule for load_m; load_h>MAX_HOURS gives MAX_HOURS.
  - Next state IDLE; expired drops the cycle after the load.
- start: accepted from IDLE or PAUSED only if the value is non-zero; next state RUN. With a value of 00:00:00 it is ignored and the state stays unchanged.
- pause: from RUN gives PAUSED; a tick in the same cycle is not applied.
- Decrement (state RUN, tick=1), registered, one cycle latency:
  - seconds>0: seconds-1.
  - seconds=0, minutes>0: seconds=SEC_LIMIT, minutes-1.
  - seconds=0, minutes=0, hours>0: seconds=minutes=SEC_LIMIT, hours-1.
- Expiry:
  - A decrement whose result is 00:00:00 sets state EXPIRED on the same edge.
  - done=1 for exactly that one cycle; running=0 from that cycle.
- start, pause and tick in EXPIRED: ignored.
- tick in the same cycle as start from IDLE/PAUSED: no decrement that cycle; the first decrement uses the next tick.
- running is a registered state decode, so it rises the cycle after start is sampled.
- Outputs are registered; digits never leave their ranges: seconds/minutes 0..SEC_LIMIT, hours 0..MAX_HOURS.
- Reset asserted mid-countdown: immediate return to reset values. After release, the timer stays IDLE until a new load and start.

Test Plan:
- Reset then load 00:01:05 and start; apply 5 ticks. Required: 00:01:00. Sixth tick gives 00:00:59 (borrow wraps seconds to 59, minutes to 0).
- Load 01:00:00 and start; one tick. Required: 00:59:59 with running=1.
- Load 00:00:02 and start; two ticks. Required: 00:00:00, done pulses exactly one cycle, expired=1, running=0. Further ticks and start leave everything unchanged.
- Load 99:75:80 (MAX_HOURS=23). Required: 23:59:59. Start with 00:00:00 loaded gives running=0 and state stays IDLE.
- Start, pause with a simultaneous tick. Required: value unchanged, running=0. Start again; next tick decrements by 1. Load while in RUN is ignored.
- Mid-countdown at 00:10:30, assert rst_n=0 asynchronously between edges. Required: outputs zero immediately. After release, ticks cause no change. Clear with load in the same cycle gives 00:00:00 and IDLE.
